// File: rtl/lfsr_seq_gen.sv
// lfsr_seq_gen: Fibonacci LFSR symbol sequence generator with a latched seed,
// a step index and round-complete detection. The same sequence can be
// replayed from the latched seed with rewind.
module lfsr_seq_gen #(
  parameter int unsigned           WIDTH      = 8,
  parameter logic [WIDTH-1:0]      TAPS       = 8'hB8,
  parameter int unsigned           SYM_BITS   = 2,
  parameter int unsigned           LEN_W      = 5,
  parameter logic [WIDTH-1:0]      RESET_SEED = 8'h01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    seed_in,
  input  logic                load,
  input  logic                rewind,
  input  logic                step,
  input  logic [LEN_W-1:0]    round_len,
  output logic [WIDTH-1:0]    state,
  output logic [SYM_BITS-1:0] sym,
  output logic [LEN_W-1:0]    idx,
  output logic                done
);

  // Single active command after applying load > rewind > step priority.
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_REWIND,
    CMD_STEP
  } cmd_e;

  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [LEN_W-1:0] idx_q,  idx_d;
  logic [WIDTH-1:0] seed_ld;
  logic [WIDTH-1:0] lfsr_next;
  logic             fb;
  logic             done_w;
  cmd_e             cmd;

  // Feedback, shift, zero-seed substitution and round completion.
  always_comb begin
    fb        = ^(lfsr_q & TAPS);
    lfsr_next = {lfsr_q[WIDTH-2:0], fb};
    seed_ld   = (seed_in == '0) ? WIDTH'(1) : seed_in;
    done_w    = (idx_q >= round_len);
  end

  // Command decode; a step is dropped once the round is complete.
  always_comb begin
    cmd = CMD_NONE;
    if (load)                 cmd = CMD_LOAD;
    else if (rewind)          cmd = CMD_REWIND;
    else if (step && !done_w) cmd = CMD_STEP;
  end

  // Next-state selection for seed, LFSR and step index.
  always_comb begin
    seed_d = seed_q;
    lfsr_d = lfsr_q;
    idx_d  = idx_q;
    unique case (cmd)
      CMD_LOAD: begin
        seed_d = seed_ld;
        lfsr_d = seed_ld;
        idx_d  = '0;
      end
      CMD_REWIND: begin
        lfsr_d = seed_q;
        idx_d  = '0;
      end
      CMD_STEP: begin
        // All-zero state cannot advance; recover from the latched seed.
        lfsr_d = (lfsr_q == '0) ? seed_q : lfsr_next;
        idx_d  = idx_q + LEN_W'(1);
      end
      default: ;
    endcase
  end

  // State registers with asynchronous reset to the reset seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q <= RESET_SEED;
      lfsr_q <= RESET_SEED;
      idx_q  <= '0;
    end else begin
      seed_q <= seed_d;
      lfsr_q <= lfsr_d;
      idx_q  <= idx_d;
    end
  end

  assign state = lfsr_q;
  assign sym   = lfsr_q[SYM_BITS-1:0];
  assign idx   = idx_q;
  assign done  = done_w;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Self-checking bench for lfsr_seq_gen with default parameters.
module tb_lfsr_seq_gen;

  localparam logic [7:0] M_TAPS = 8'hB8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seed_in;
  logic       load, rewind, step;
  logic [4:0] round_len;
  logic [7:0] state;
  logic [1:0] sym;
  logic [4:0] idx;
  logic       done;

  int checks = 0;
  int passes = 0;

  // Reference model state.
  int m_seed;
  int m_lfsr;
  int m_idx;

  lfsr_seq_gen #(
    .WIDTH(8), .TAPS(8'hB8), .SYM_BITS(2), .LEN_W(5), .RESET_SEED(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .seed_in(seed_in), .load(load), .rewind(rewind),
    .step(step), .round_len(round_len), .state(state), .sym(sym), .idx(idx),
    .done(done)
  );

  always #5 clk = ~clk;

  // Next LFSR value: double modulo 256, add the parity of the tapped bits.
  function automatic int model_next(input int s);
    logic [7:0] t;
    t = 8'(s) & M_TAPS;
    return (s * 2 + ($countones(t) % 2)) % 256;
  endfunction

  function automatic int model_done();
    return (m_idx >= int'(round_len)) ? 1 : 0;
  endfunction

  // Drive one command cycle and advance the model by the same rules.
  task automatic cmd(input logic l, input logic r, input logic s, input logic [7:0] sd);
    int dn;
    @(negedge clk);
    load = l; rewind = r; step = s; seed_in = sd;
    dn = model_done();
    @(posedge clk);
    if (l) begin
      m_seed = (sd == 8'h00) ? 1 : int'(sd);
      m_lfsr = m_seed;
      m_idx  = 0;
    end else if (r) begin
      m_lfsr = m_seed;
      m_idx  = 0;
    end else if (s && dn == 0) begin
      m_lfsr = (m_lfsr == 0) ? m_seed : model_next(m_lfsr);
      m_idx  = m_idx + 1;
    end
    #1;
    load = 1'b0; rewind = 1'b0; step = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 0; rewind = 0; step = 0; seed_in = 8'h00; round_len = 5'd5;
    m_seed = 1; m_lfsr = 1; m_idx = 0;
    #12;
    checks++; if (state !== 8'h01) $display("FAIL reset_state: got %h want 01", state); else passes++;
    checks++; if (sym !== 2'd1) $display("FAIL reset_sym: got %0d want 1", sym); else passes++;
    checks++; if (idx !== 5'd0) $display("FAIL reset_idx: got %0d want 0", idx); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done_len5: got %b want 0", done); else passes++;
    round_len = 5'd0; #1;
    checks++; if (done !== 1'b1) $display("FAIL reset_done_len0: got %b want 1", done); else passes++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_sequence();
    logic [7:0] exp_st [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    logic [1:0] exp_sy [6] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3};
    round_len = 5'd5;
    cmd(1, 0, 0, 8'h01);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cmd(0, 0, 1, 8'h00);
      checks++; if (state !== exp_st[i]) $display("FAIL seq_state[%0d]: got %h want %h", i, state, exp_st[i]); else passes++;
      checks++; if (sym !== exp_sy[i]) $display("FAIL seq_sym[%0d]: got %0d want %0d", i, sym, exp_sy[i]); else passes++;
      checks++; if (idx !== 5'(i)) $display("FAIL seq_idx[%0d]: got %0d want %0d", i, idx, i); else passes++;
      checks++; if (done !== (i == 5)) $display("FAIL seq_done[%0d]: got %b want %b", i, done, (i == 5)); else passes++;
    end
    // Steps past the end of the round are ignored.
    for (int i = 0; i < 3; i++) begin
      cmd(0, 0, 1, 8'h00);
      checks++; if (state !== 8'h23) $display("FAIL hold_state[%0d]: got %h want 23", i, state); else passes++;
      checks++; if (idx !== 5'd5) $display("FAIL hold_idx[%0d]: got %0d want 5", i, idx); else passes++;
    end
  endtask

  task automatic test_rewind();
    round_len = 5'd10;
    cmd(1, 0, 0, 8'h01);
    repeat (3) cmd(0, 0, 1, 8'h00);
    checks++; if (state !== 8'h08) $display("FAIL rw_pass1: got %h want 08", state); else passes++;
    cmd(0, 1, 0, 8'h00);
    checks++; if (idx !== 5'd0) $display("FAIL rw_idx: got %0d want 0", idx); else passes++;
    checks++; if (state !== 8'h01) $display("FAIL rw_state: got %h want 01", state); else passes++;
    repeat (3) cmd(0, 0, 1, 8'h00);
    checks++; if (state !== 8'h08) $display("FAIL rw_pass2: got %h want 08", state); else passes++;
  endtask

  task automatic test_zero_seed();
    round_len = 5'd10;
    cmd(1, 0, 0, 8'h00);
    checks++; if (state !== 8'h01) $display("FAIL zero_seed: got %h want 01", state); else passes++;
    cmd(0, 0, 1, 8'h00);
    checks++; if (state !== 8'h02) $display("FAIL zero_seed_step: got %h want 02", state); else passes++;
  endtask

  task automatic test_priority();
    round_len = 5'd10;
    cmd(1, 0, 1, 8'h40);
    checks++; if (state !== 8'h40 || idx !== 5'd0) $display("FAIL load_step: got %h/%0d want 40/0", state, idx); else passes++;
    cmd(0, 0, 1, 8'h00);
    cmd(0, 1, 1, 8'h00);
    checks++; if (state !== 8'h40 || idx !== 5'd0) $display("FAIL rewind_step: got %h/%0d want 40/0", state, idx); else passes++;
    // load together with rewind: the new seed is what a later rewind uses
    cmd(1, 1, 0, 8'h33);
    cmd(0, 0, 1, 8'h00);
    cmd(0, 1, 0, 8'h00);
    checks++; if (state !== 8'h33 || idx !== 5'd0) $display("FAIL load_rewind: got %h/%0d want 33/0", state, idx); else passes++;
  endtask

  task automatic test_async_reset();
    round_len = 5'd10;
    cmd(1, 0, 0, 8'h5A);
    repeat (3) cmd(0, 0, 1, 8'h00);
    checks++; if (idx !== 5'd3) $display("FAIL ar_pre_idx: got %0d want 3", idx); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (state !== 8'h01 || idx !== 5'd0) $display("FAIL ar_clear: got %h/%0d want 01/0", state, idx); else passes++;
    m_seed = 1; m_lfsr = 1; m_idx = 0;
    @(negedge clk); rst = 1'b0;
    cmd(0, 1, 0, 8'h00);
    checks++; if (state !== 8'h01 || idx !== 5'd0) $display("FAIL ar_rewind: got %h/%0d want 01/0", state, idx); else passes++;
  endtask

  task automatic test_random();
    logic l, r, s;
    int replay [$];
    int check_replay;
    check_replay = 0;
    round_len = 5'($urandom_range(0, 31));
    cmd(1, 0, 0, 8'($urandom));
    replay.delete(); replay.push_back(int'(state));
    for (int n = 0; n < 400; n++) begin
      l = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 14) == 0);
      s = ($urandom_range(0, 3) != 0);
      if (l) round_len = 5'($urandom_range(0, 31));
      cmd(l, r, s, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      checks++;
      if (state !== 8'(m_lfsr) || idx !== 5'(m_idx) || sym !== 2'(m_lfsr) || done !== model_done())
        $display("FAIL rand[%0d]: got st=%h idx=%0d sym=%0d done=%b want st=%h idx=%0d sym=%0d done=%0d",
                 n, state, idx, sym, done, 8'(m_lfsr), m_idx, m_lfsr % 4, model_done());
      else passes++;
      // Replay after rewind must reproduce the first pass.
      if (l) begin
        replay.delete(); replay.push_back(int'(state)); check_replay = 0;
      end else if (r) begin
        check_replay = 1;
      end
      if (check_replay == 1 && m_idx < replay.size()) begin
        checks++;
        if (int'(state) != replay[m_idx]) $display("FAIL replay[%0d]: got %h want %h", n, state, 8'(replay[m_idx]));
        else passes++;
      end else if (check_replay == 0 && m_idx == replay.size()) begin
        replay.push_back(int'(state));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_rewind();
    test_zero_seed();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_gen.md
# lfsr_seq_gen

Parametrised pseudo-random symbol sequence generator for the game core. It holds a Fibonacci LFSR with configurable width and tap mask, plus a latched seed and a step index. The controller can advance it one symbol at a time, rewind it to regenerate the identical sequence for checking the player, and detect the end of a round of programmable length. It sits between the game FSM (which issues load/rewind/step and the round length) and the LED/tone output stage (which consumes `sym`).

## Interface

Parameters:

- `WIDTH`, 8, LFSR state width (≥ 3).
- `TAPS`, 8'hB8, feedback tap mask, WIDTH bits; bit i set means state[i] feeds the XOR.
- `SYM_BITS`, 2, symbol width taken from the LFSR LSBs (≤ WIDTH).
- `LEN_W`, 5, width of the round length and the step index.
- `RESET_SEED`, 8'h01, reset value of the seed and state registers, WIDTH bits, non-zero.

Ports:

- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `seed_in`  in  WIDTH  seed value, captured on `load`.
- `load`  in  1  capture the seed, restart the sequence.
- `rewind`  in  1  restart the sequence from the latched seed.
- `step`  in  1  advance one symbol.
- `round_len`  in  LEN_W  number of steps in the current round; held stable by the controller.
- `state`  out  WIDTH  current LFSR register.
- `sym`  out  SYM_BITS  current symbol, equal to state[SYM_BITS-1:0].
- `idx`  out  LEN_W  steps taken since the last load or rewind.
- `done`  out  1  round complete.

## Operation

- Registers: `seed_reg` (WIDTH), `lfsr` (WIDTH), `idx` (LEN_W). All outputs are driven from these registers or from simple combinational logic on them.
- Feedback: fb = XOR-reduce(lfsr & TAPS). Next state = {lfsr[WIDTH-2:0], fb}, a left shift with fb entering at bit 0.
- Command priority per cycle: `load` > `rewind` > `step`. Only the highest active command acts.
- `load`:
  - `seed_reg` and `lfsr` take `seed_in`. If `seed_in` == 0, both take 1 instead, so the LFSR never locks up.
  - `idx` becomes 0.
- `rewind`: `lfsr` takes `seed_reg`, `idx` becomes 0, and `seed_reg` is unchanged.
- `step`:
  - Acts only when `done` == 0. A step while `done` == 1 is ignored, and all registers hold.
  - Normally: `lfsr` takes the next state and `idx` increments.
  - If `lfsr` == 0 (unreachable with a legal seed), `lfsr` reloads `seed_reg` and `idx` still increments.
- `done` = (`idx` >= `round_len`), combinational.
  - `round_len` == 0 gives `done` = 1 immediately after load or rewind.
  - Because stepping stops at `done`, `idx` never exceeds `round_len` and never wraps.
- With no command active, all registers hold.
- A replay after `rewind` reproduces exactly the same `sym` sequence as the original pass, for the same seed and TAPS.

## Timing

- Reset, asynchronous: `seed_reg` = `lfsr` = RESET_SEED and `idx` = 0, taking effect immediately without waiting for a clock edge.
  - Outputs in reset: `state` = RESET_SEED, `sym` = RESET_SEED[SYM_BITS-1:0], `idx` = 0.
  - `done` = (0 >= `round_len`).
- Deassertion of `rst` is synchronised externally. The first command is honoured on the first rising edge with `rst` low.
- Reset asserted mid-round aborts the round with no residual state.
- Latency is one cycle for every command. The new `state`, `sym` and `idx` are visible after the edge that samples the command.
- `done` updates in the same cycle as `idx`, and changes combinationally with `round_len`.
- Single-cycle pulses are expected on all commands. A held `step` advances once per cycle until `done`.
- `load` and `step` in the same cycle: the load wins and no step occurs. Same for `rewind` with `step`.
- `load` and `rewind` in the same cycle: the load wins, and the rewind effectively uses the new seed.

## Test plan

- Reset, then `load` with `seed_in`=0x01 and `round_len`=5, then 5 steps. `state` must go 0x01 → 0x02 → 0x04 → 0x08 → 0x11 → 0x23, `sym` 1,2,0,0,1,3, `idx` 0→5, and `done` rises on the 5th step.
- After the previous scenario, 3 extra steps. `state` must hold at 0x23 and `idx` at 5.
- `load` 0x01, 3 steps, then `rewind`, then 3 steps. `state` must be 0x08 after each 3-step pass, and `idx` 0 right after the rewind.
- `load` with `seed_in`=0x00. `state` must be 0x01, and one step must give 0x02.
- `load` and `step` asserted together with `seed_in`=0x40. `state` must be 0x40 and `idx` 0. A further `rewind` asserted with `step` gives 0x40 and `idx` 0.
- Assert `rst` mid-edge while at `idx`=3 with seed 0x5A. Outputs must clear immediately to `state`=0x01 and `idx`=0, and `rewind` after release must give 0x01.
